// File: rtl/lfsr_bank.sv
// Multi-channel leap-forward LFSR bank with seed load, warm-up and back-pressure.
// Optional draw counter port enabled by defining LFSR_BANK_STATS_EN.
module lfsr_bank #(
  parameter int STATE_W = 130,
  parameter int TAP_A   = 7,
  parameter int TAP_B   = 10,
  parameter int NUM_OUT = 4,
  parameter int OUT_W   = 32,
  parameter int WARMUP  = 8,
  parameter logic [STATE_W-1:0] DEFAULT_SEED =
    130'h123456789bdefa2154acbd55a468daf5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seed_valid,
  output logic                     seed_ready,
  input  logic [STATE_W-1:0]       seed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OUT*OUT_W-1:0] data
`ifdef LFSR_BANK_STATS_EN
  ,
  output logic [31:0]              draw_count
`endif
);

  localparam int P = STATE_W - TAP_B;
  localparam logic [15:0] LAST =
    16'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic {
    ST_WARM,
    ST_RUN
  } fsm_t;

  localparam fsm_t FSM_INIT =
    (WARMUP == 0) ? ST_RUN : ST_WARM;

  if (!(TAP_A > 0 && TAP_A < TAP_B && TAP_B < STATE_W))
  begin : g_bad_taps
    $error("lfsr_bank: need 0 < TAP_A < TAP_B < STATE_W");
  end

  if (NUM_OUT * OUT_W > STATE_W) begin : g_bad_width
    $error("lfsr_bank: NUM_OUT*OUT_W exceeds STATE_W");
  end

  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] s_step;
  logic [15:0]        cnt;
  fsm_t               fsm;
  fsm_t               fsm_nxt;
  logic               seed_hs;
  logic               out_hs;

  assign seed_hs = seed_valid && seed_ready;
  assign out_hs  = out_valid && out_ready;

  // One leap-forward step: low bits from two taps, high bits wrap around.
  always_comb begin
    s_step = '0;
    for (int i = 0; i < P; i++) begin
      s_step[i] = s[i + TAP_A] ^ s[i + TAP_B];
    end
    for (int i = P; i < STATE_W; i++) begin
      s_step[i] = s[i - P];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= FSM_INIT;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // FSM next state: seed load restarts warm-up from any state.
  always_comb begin
    fsm_nxt = fsm;
    if (seed_hs) begin
      fsm_nxt = FSM_INIT;
    end else begin
      unique case (fsm)
        ST_WARM: if (cnt == LAST) fsm_nxt = ST_RUN;
        ST_RUN:  fsm_nxt = ST_RUN;
        default: fsm_nxt = FSM_INIT;
      endcase
    end
  end

  // FSM outputs: draws are only presented in RUN.
  always_comb begin
    out_valid = (fsm == ST_RUN);
    data      = s[NUM_OUT*OUT_W-1:0];
  end

  // State, warm-up counter and seed acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s          <= DEFAULT_SEED;
      cnt        <= '0;
      seed_ready <= 1'b0;
    end else begin
      seed_ready <= 1'b1;
      if (seed_hs) begin
        s   <= (seed == '0) ? DEFAULT_SEED : seed;
        cnt <= '0;
      end else if (fsm == ST_WARM) begin
        s   <= s_step;
        cnt <= cnt + 16'd1;
      end else if (out_hs) begin
        s <= s_step;
      end
    end
  end

`ifdef LFSR_BANK_STATS_EN
  // Accepted-draw counter; a draw taken alongside a seed load counts as 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_count <= '0;
    end else if (seed_hs) begin
      draw_count <= out_hs ? 32'd1 : 32'd0;
    end else if (out_hs) begin
      draw_count <= draw_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Testbench for lfsr_bank: three instances (warm-up 8, warm-up 0, 64-bit).
// Draws are checked against a shift/xor reference through scoreboard queues.
module tb_lfsr_bank;

  localparam logic [129:0] DS =
    130'h123456789bdefa2154acbd55a468daf5;
  localparam logic [63:0] DS64 = 64'h0123456789abcdef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic         ra, sva, sra, ova, ora;
  logic [129:0] seeda;
  logic [127:0] da;
  logic         rb, svb, srb, ovb, orb;
  logic [129:0] seedb;
  logic [127:0] db;
  logic         rc, svc, src, ovc, orc;
  logic [63:0]  seedc;
  logic [31:0]  dc;
`ifdef LFSR_BANK_STATS_EN
  logic [31:0]  dca, dcb, dcc;
`endif

  logic [129:0] qa[$];
  logic [129:0] qb[$];
  logic [63:0]  qc[$];

  lfsr_bank u_a (
    .clk(clk), .reset(ra),
    .seed_valid(sva), .seed_ready(sra), .seed(seeda),
    .out_valid(ova), .out_ready(ora), .data(da)
`ifdef LFSR_BANK_STATS_EN
    , .draw_count(dca)
`endif
  );

  lfsr_bank #(.WARMUP(0)) u_b (
    .clk(clk), .reset(rb),
    .seed_valid(svb), .seed_ready(srb), .seed(seedb),
    .out_valid(ovb), .out_ready(orb), .data(db)
`ifdef LFSR_BANK_STATS_EN
    , .draw_count(dcb)
`endif
  );

  lfsr_bank #(
    .STATE_W(64), .TAP_A(5), .TAP_B(9),
    .NUM_OUT(2), .OUT_W(16), .WARMUP(8),
    .DEFAULT_SEED(DS64)
  ) u_c (
    .clk(clk), .reset(rc),
    .seed_valid(svc), .seed_ready(src), .seed(seedc),
    .out_valid(ovc), .out_ready(orc), .data(dc)
`ifdef LFSR_BANK_STATS_EN
    , .draw_count(dcc)
`endif
  );

  function automatic logic [129:0] st130(input logic [129:0] s);
    logic [129:0] a;
    logic [129:0] b;
    a = s >> 7;
    b = s >> 10;
    return {s[9:0], a[119:0] ^ b[119:0]};
  endfunction

  function automatic logic [129:0] st130n(input logic [129:0] s,
                                          input int n);
    logic [129:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = st130(r);
    return r;
  endfunction

  function automatic logic [63:0] st64(input logic [63:0] s);
    logic [63:0] a;
    logic [63:0] b;
    a = s >> 5;
    b = s >> 9;
    return {s[8:0], a[54:0] ^ b[54:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int n, input bit rnd);
    logic [129:0] x;
    bit r;
    for (int i = 0; i < n; i++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ova) begin
        n_chk++;
        if (qa.size() == 0) begin
          $display("FAIL a_stream empty queue got %h", da);
        end else begin
          x = qa[0];
          if (da !== x[127:0])
            $display("FAIL a_stream got %h want %h", da, x[127:0]);
          else n_pass++;
          if (r) begin
            x = qa.pop_front();
            qa.push_back(st130(x));
          end
        end
      end
      ora = r;
      tick();
    end
    ora = 1'b0;
  endtask

  task automatic test_reset;
    logic [129:0] e;
    e = DS;
    ra = 1'b1;
    tick();
    tick();
    n_chk++;
    if (ova !== 1'b0) $display("FAIL rst_valid got %b want 0", ova);
    else n_pass++;
    n_chk++;
    if (sra !== 1'b0) $display("FAIL rst_seed_ready got %b want 0", sra);
    else n_pass++;
    n_chk++;
    if (da !== e[127:0]) $display("FAIL rst_data got %h want %h", da, e[127:0]);
    else n_pass++;
`ifdef LFSR_BANK_STATS_EN
    n_chk++;
    if (dca !== 32'd0) $display("FAIL rst_count got %0d want 0", dca);
    else n_pass++;
`endif
  endtask

  task automatic test_warmup;
    logic [129:0] e;
    ora = 1'b0;
    ra  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        n_chk++;
        if (sra !== 1'b1) $display("FAIL seed_ready_rise got %b want 1", sra);
        else n_pass++;
      end
      n_chk++;
      if (ova !== (i == 8))
        $display("FAIL warm_valid edge %0d got %b want %b", i, ova, i == 8);
      else n_pass++;
    end
    e = st130n(DS, 8);
    qa.delete();
    qa.push_back(e);
    n_chk++;
    if (da !== e[127:0]) $display("FAIL warm_data got %h want %h", da, e[127:0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (ova !== 1'b1 || da !== e[127:0])
        $display("FAIL hold got v=%b %h want v=1 %h", ova, da, e[127:0]);
      else n_pass++;
    end
    run_a(20, 1'b0);
    run_a(20, 1'b1);
  endtask

  task automatic test_seed_zero;
    logic [129:0] e;
    e = DS;
    sva   = 1'b1;
    seeda = '0;
    tick();
    sva = 1'b0;
    n_chk++;
    if (da !== e[127:0] || ova !== 1'b0)
      $display("FAIL seed0_load got v=%b %h want v=0 %h", ova, da, e[127:0]);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (ova !== (i == 8))
        $display("FAIL seed0_warm edge %0d got %b want %b", i, ova, i == 8);
      else n_pass++;
    end
    qa.delete();
    qa.push_back(st130n(DS, 8));
    run_a(12, 1'b0);
  endtask

  task automatic test_seed_with_draw;
    n_chk++;
    if (ova !== 1'b1) $display("FAIL sd_pre_valid got %b want 1", ova);
    else n_pass++;
    ora   = 1'b1;
    sva   = 1'b1;
    seeda = 130'h1;
    tick();
    sva = 1'b0;
    ora = 1'b0;
    n_chk++;
    if (da !== 128'h1 || ova !== 1'b0)
      $display("FAIL sd_load got v=%b %h want v=0 1", ova, da);
    else n_pass++;
`ifdef LFSR_BANK_STATS_EN
    n_chk++;
    if (dca !== 32'd1) $display("FAIL sd_count got %0d want 1", dca);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_midwarm;
    logic [129:0] e;
    e = DS;
    tick();
    tick();
    tick();
    ra    = 1'b1;
    sva   = 1'b1;
    seeda = 130'h5;
    ora   = 1'b1;
    tick();
    ra  = 1'b0;
    sva = 1'b0;
    ora = 1'b0;
    n_chk++;
    if (da !== e[127:0] || ova !== 1'b0 || sra !== 1'b0)
      $display("FAIL rst_prio got v=%b r=%b %h want v=0 r=0 %h",
               ova, sra, da, e[127:0]);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (ova !== (i == 8))
        $display("FAIL rst_warm edge %0d got %b want %b", i, ova, i == 8);
      else n_pass++;
    end
    e = st130n(DS, 8);
    n_chk++;
    if (da !== e[127:0]) $display("FAIL rst_warm_data got %h want %h", da, e[127:0]);
    else n_pass++;
  endtask

  task automatic test_no_warmup;
    logic [129:0] x;
    rb  = 1'b1;
    orb = 1'b1;
    tick();
    tick();
    n_chk++;
    if (ovb !== 1'b1) $display("FAIL w0_rst_valid got %b want 1", ovb);
    else n_pass++;
    rb = 1'b0;
    qb.delete();
    qb.push_back(DS);
    for (int i = 0; i < 200; i++) begin
      x = qb.pop_front();
      n_chk++;
      if (ovb !== 1'b1 || db !== x[127:0])
        $display("FAIL w0_stream %0d got v=%b %h want v=1 %h",
                 i, ovb, db, x[127:0]);
      else n_pass++;
      qb.push_back(st130(x));
      tick();
    end
    orb   = 1'b0;
    svb   = 1'b1;
    seedb = 130'h5;
    tick();
    svb = 1'b0;
    n_chk++;
    if (ovb !== 1'b1 || db !== 128'h5)
      $display("FAIL w0_seed got v=%b %h want v=1 5", ovb, db);
    else n_pass++;
  endtask

  task automatic test_small_config;
    logic [63:0] x;
    bit r;
    rc = 1'b1;
    tick();
    tick();
    rc = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    x = DS64;
    for (int i = 0; i < 8; i++) x = st64(x);
    qc.delete();
    qc.push_back(x);
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom_range(0, 1));
      x = qc[0];
      n_chk++;
      if (ovc !== 1'b1 || dc !== x[31:0])
        $display("FAIL c_stream %0d got v=%b %h want v=1 %h",
                 i, ovc, dc, x[31:0]);
      else n_pass++;
      if (r) begin
        x = qc.pop_front();
        qc.push_back(st64(x));
      end
      orc = r;
      tick();
    end
    orc = 1'b0;
  endtask

  initial begin
    ra = 1'b1; sva = 1'b0; ora = 1'b0; seeda = '0;
    rb = 1'b1; svb = 1'b0; orb = 1'b0; seedb = '0;
    rc = 1'b1; svc = 1'b0; orc = 1'b0; seedc = '0;
    test_reset();
    test_warmup();
    test_seed_zero();
    test_seed_with_draw();
    test_reset_midwarm();
    test_no_warmup();
    test_small_config();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
